// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter slice.
//   state_t      : controller FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   DW_DEF       : default operand/result width
//   ADD_LAT_DEF  : default adder latency in cycles
//   clog2()      : index width helper, never returns less than 1
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DW_DEF      = 32;
  localparam int ADD_LAT_DEF = 5;

  // Minimum of 1 so a degenerate parameter still yields a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin search.
//   req   : request vector
//   ptr   : index of the last winner (lowest priority this round)
//   any   : at least one request present
//   idx   : winner index, first set bit at ptr+1, ptr+2, ... with wrap
//   grant : one-hot form of idx (all zero when any is low)
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    idx,
  output logic [N_REQ-1:0] grant
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % N_REQ);
  endfunction

  always_comb begin
    any   = 1'b0;
    idx   = '0;
    grant = '0;
    // k = N_REQ lands back on ptr itself, so the last winner is checked last.
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any && req[wrap_idx(ptr, k)]) begin
        any                   = 1'b1;
        idx                   = wrap_idx(ptr, k);
        grant[wrap_idx(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one multi-cycle sign-magnitude adder among N_REQ requesters.
// One operation in flight: arbitrate (IDLE), start adder (ISSUE),
// wait ADD_LAT cycles (WAIT), return result (DONE).
//   clk, rst            : clock, async active-high reset
//   req_valid/a/b/cin   : per-requester request and packed operands
//   req_ready           : one-hot pulse, operands captured
//   rsp_valid, rsp_sum  : one-hot completion pulse and held result
//   add_en/a/b/cin      : adder start pulse and registered operands
//   add_sum             : adder result, sampled at end of WAIT
//   busy                : controller not idle
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = DW_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  input  logic [N_REQ-1:0]    req_cin,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_sum,
  output logic                add_en,
  output logic [DW-1:0]       add_a,
  output logic [DW-1:0]       add_b,
  output logic                add_cin,
  input  logic [DW-1:0]       add_sum,
  output logic                busy
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(ADD_LAT);

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr, grant;
  logic [CW-1:0]     cnt;
  logic              arb_any;
  logic [IW-1:0]     arb_idx;
  logic [N_REQ-1:0]  arb_oh;
  logic [DW-1:0]     sel_a, sel_b;
  logic              sel_cin;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .any   (arb_any),
    .idx   (arb_idx),
    .grant (arb_oh)
  );

  // AND-OR operand select driven by the one-hot winner.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_oh[i]) begin
        sel_a   = sel_a | req_a[i*DW +: DW];
        sel_b   = sel_b | req_b[i*DW +: DW];
        sel_cin = sel_cin | req_cin[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    add_en    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (arb_any) state_nxt = ISSUE;
      ISSUE: begin
        add_en    = 1'b1;
        req_ready = N_REQ'(1) << grant;
        state_nxt = WAIT;
      end
      WAIT:  if (cnt == '0) state_nxt = DONE;
      DONE: begin
        rsp_valid = N_REQ'(1) << grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // IDLE -> ISSUE: capture winner operands; WAIT -> DONE: capture sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= IW'(N_REQ - 1);
      grant   <= '0;
      cnt     <= '0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      rsp_sum <= '0;
    end else begin
      if (state == IDLE && arb_any) begin
        add_a   <= sel_a;
        add_b   <= sel_b;
        add_cin <= sel_cin;
        grant   <= arb_idx;
        ptr     <= arb_idx;
      end
      if (state == ISSUE) cnt <= CW'(ADD_LAT - 1);
      if (state == WAIT) begin
        if (cnt == '0) rsp_sum <= add_sum;
        else           cnt     <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int N_REQ = 4, DW = 32, ADD_LAT = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid, req_cin, req_ready, rsp_valid;
  logic [N_REQ*DW-1:0] req_a, req_b;
  logic [DW-1:0]       rsp_sum, add_a, add_b, add_sum;
  logic                add_en, add_cin, busy;

  int errors = 0, checks = 0, cyc = 0;

  typedef struct { int idx; logic [DW-1:0] sum; } exp_t;
  exp_t sb[$];

  adder_arbiter #(.N_REQ(N_REQ), .DW(DW), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sign-magnitude adder model, result lands 3 cycles after add_en.
  function automatic logic [DW-1:0] sm_add(input logic [DW-1:0] a, b, input logic c);
    longint va, vb, s;
    va = a[DW-1] ? -longint'(a[DW-2:0]) : longint'(a[DW-2:0]);
    vb = b[DW-1] ? -longint'(b[DW-2:0]) : longint'(b[DW-2:0]);
    s  = va + vb + longint'(c);
    if (s < 0) return {1'b1, (DW-1)'(-s)};
    return {1'b0, (DW-1)'(s)};
  endfunction

  logic [DW-1:0] pend = '0;
  int acnt = 0;
  initial add_sum = '0;
  always @(posedge clk) begin
    if (add_en) begin
      pend <= sm_add(add_a, add_b, add_cin);
      acnt <= 3;
    end else if (acnt > 0) begin
      acnt <= acnt - 1;
      if (acnt == 1) add_sum <= pend;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Invariants sampled every falling edge.
  always @(negedge clk) begin
    chk("inv_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    chk("inv_rsp_onehot0", 64'($onehot0(rsp_valid)), 64'd1);
    chk("inv_ready_rsp_excl", 64'((|req_ready) && (|rsp_valid)), 64'd0);
    chk("inv_add_en_issue", 64'(add_en), 64'(|req_ready));
  end

  task automatic set_req(input int i, input logic [DW-1:0] a, b, input logic c);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_cin[i]        = c;
  endtask

  task automatic wait_ready(input string tag, input int exp_idx, output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (|req_ready) begin found = 1'b1; at = cyc; break; end
    end
    chk({tag, "_ready_seen"}, 64'(found), 64'd1);
    if (found) chk({tag, "_ready_vec"}, 64'(req_ready), 64'(4'b0001 << exp_idx));
  endtask

  task automatic wait_rsp(input string tag, output int at);
    logic found;
    exp_t e;
    found = 1'b0;
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (|rsp_valid) begin found = 1'b1; at = cyc; break; end
    end
    chk({tag, "_rsp_seen"}, 64'(found), 64'd1);
    if (found) begin
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_rsp_vec"}, 64'(rsp_valid), 64'(4'b0001 << e.idx));
        chk({tag, "_rsp_sum"}, 64'(rsp_sum), 64'(e.sum));
      end
    end
  endtask

  task automatic do_op(input string tag, input int i, input logic [DW-1:0] a, b,
                       input logic c, input logic [DW-1:0] exp_sum);
    int t0, tr, tv;
    @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    set_req(i, a, b, c);
    req_valid[i] = 1'b1;
    t0 = cyc + 1;
    sb.push_back('{i, exp_sum});
    wait_ready(tag, i, tr);
    req_valid[i] = 1'b0;
    chk({tag, "_ready_lat"}, 64'(tr), 64'(t0));
    chk({tag, "_add_a"}, 64'(add_a), 64'(a));
    chk({tag, "_add_b"}, 64'(add_b), 64'(b));
    wait_rsp(tag, tv);
    chk({tag, "_rsp_lat"}, 64'(tv), 64'(t0 + ADD_LAT + 1));
  endtask

  initial begin
    int tr, tv, tprev;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_add", 64'({add_en, add_cin, add_a, add_b}), 64'd0);
    rst = 1'b0;

    // Plain adds and a mixed-sign add.
    do_op("t1", 0, 32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_000C);
    do_op("t2", 2, 32'h0000_0003, 32'h8000_0005, 1'b0, 32'h8000_0002);

    // Last grant was 2: requesters 1 and 3 together, 3 wins first.
    @(negedge clk);
    set_req(3, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set_req(1, 32'h0000_0001, 32'h0000_0001, 1'b1);
    req_valid = 4'b1010;
    sb.push_back('{3, 32'h0000_0030});
    sb.push_back('{1, 32'h0000_0003});
    wait_ready("t5a", 3, tr);
    req_valid[3] = 1'b0;
    wait_rsp("t5a", tv);
    wait_ready("t5b", 1, tr);
    req_valid[1] = 1'b0;
    wait_rsp("t5b", tv);
    repeat (2) @(negedge clk);
    chk("t3_sum_held", 64'(rsp_sum), 64'h3);

    // Fresh reset, all four held: grants 0,1,2,3,0 spaced ADD_LAT+3.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, DW'(i + 10), DW'(3 * i), 1'b0);
    for (int n = 0; n < 5; n++) sb.push_back('{n % N_REQ, DW'((n % N_REQ) + 10 + 3 * (n % N_REQ))});
    req_valid = 4'b1111;
    tprev = cyc + 1 - 2;  // first completion lands ADD_LAT+1 after sampling edge
    for (int n = 0; n < 5; n++) begin
      wait_rsp("t4", tv);
      chk("t4_spacing", 64'(tv - tprev), 64'(ADD_LAT + 3));
      tprev = tv;
    end
    req_valid = '0;

    // Reset during WAIT aborts without a response.
    do_op("t6_pre", 2, 32'h0000_0004, 32'h0000_0004, 1'b0, 32'h0000_0008);
    @(negedge clk);
    set_req(1, 32'h0000_0100, 32'h0000_0200, 1'b0);
    req_valid[1] = 1'b1;
    sb.push_back('{1, 32'h0000_0300});
    wait_ready("t6_abort", 1, tr);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_busy", 64'(busy), 64'd0);
    chk("t6_async_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("t6_async_add", 64'({add_en, add_cin, add_a, add_b}), 64'd0);
    chk("t6_async_hs", 64'({req_ready, rsp_valid}), 64'd0);
    sb.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) rst = 1'b0;
      chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
    end
    for (int i = 0; i < N_REQ; i++) set_req(i, DW'(i + 1), DW'(i + 1), 1'b0);
    req_valid = 4'b1111;
    sb.push_back('{0, 32'h0000_0002});
    wait_ready("t6_after", 0, tr);
    req_valid = '0;
    wait_rsp("t6_after", tv);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
